// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 16;

    typedef enum logic {
        ModeStd  = 1'b0,
        ModeFwft = 1'b1
    } read_mode_e;

    // Ceiling log2 for elaboration-time sizing; DEPTH >= 2 so n=1 never matters.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if import fifo_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
);

    localparam int unsigned CntW = clog2(DEPTH) + 1;

    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             rd_en_i;
    logic             clr_err_i;
    logic [WIDTH-1:0] rdata_o;
    logic             rvalid_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CntW-1:0]  count_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             error_o;

    modport master (
        output wr_en_i, wdata_i, rd_en_i, clr_err_i,
        input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
        input  count_o, overflow_o, underflow_o, error_o
    );

    modport slave (
        input  wr_en_i, wdata_i, rd_en_i, clr_err_i,
        output rdata_o, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
        output count_o, overflow_o, underflow_o, error_o
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module fifo_mem import fifo_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [clog2(DEPTH)-1:0]  waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [clog2(DEPTH)-1:0]  raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read, level flags and sticky errors.
module sync_fifo_param import fifo_pkg::*; #(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4,
    parameter int unsigned FWFT      = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sync_fifo_param_if.slave  bus
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfCnt   = CntW'(AF_THRESH);
    localparam logic [CntW-1:0] AeCnt   = CntW'(AE_THRESH);
    localparam read_mode_e      Mode    = (FWFT != 0) ? ModeFwft : ModeStd;

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             full, empty, wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    assign full   = (count_q == FullCnt);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en_i && !full;
    assign rd_acc = bus.rd_en_i && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.clr_err_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (bus.wr_en_i && full)  ovf_d = 1'b1;
        if (bus.rd_en_i && empty) unf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wdata_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    if (Mode == ModeFwft) begin : gen_fwft
        // Masked while empty so the output reads zero out of reset rather than stale memory.
        assign bus.rdata_o  = empty ? '0 : mem_rdata;
        assign bus.rvalid_o = !empty;
    end else begin : gen_std
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem_rdata;
            end
        end

        assign bus.rdata_o  = rdata_q;
        assign bus.rvalid_o = rvalid_q;
    end

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (count_q >= AfCnt);
    assign bus.almost_empty_o = (count_q <= AeCnt);
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
    assign bus.error_o        = ovf_q | unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-read and an FWFT instance in lockstep against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned AF = 12;
    localparam int unsigned AE = 4;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) if_std ();
    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) if_fwft ();

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dut_std (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (if_std)
    );

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dut_fwft (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (if_fwft)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, sticky errors, last standard-mode read word.
    logic [W-1:0] mq[$];
    bit           m_ovf, m_unf, m_rv;
    logic [W-1:0] m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string p, input logic [4:0] cnt, input logic f,
                               input logic e, input logic af, input logic ae,
                               input logic ov, input logic un, input logic er);
        int n;
        n = mq.size();
        check_eq({p, "count"},        32'(cnt), 32'(n));
        check_eq({p, "full"},         32'(f),   32'(n == D));
        check_eq({p, "empty"},        32'(e),   32'(n == 0));
        check_eq({p, "almost_full"},  32'(af),  32'(n >= AF));
        check_eq({p, "almost_empty"}, 32'(ae),  32'(n <= AE));
        check_eq({p, "overflow"},     32'(ov),  32'(m_ovf));
        check_eq({p, "underflow"},    32'(un),  32'(m_unf));
        check_eq({p, "error"},        32'(er),  32'(m_ovf | m_unf));
    endtask

    task automatic check_all();
        logic [W-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check_flags("std.", if_std.count_o, if_std.full_o, if_std.empty_o,
                    if_std.almost_full_o, if_std.almost_empty_o,
                    if_std.overflow_o, if_std.underflow_o, if_std.error_o);
        check_flags("fwft.", if_fwft.count_o, if_fwft.full_o, if_fwft.empty_o,
                    if_fwft.almost_full_o, if_fwft.almost_empty_o,
                    if_fwft.overflow_o, if_fwft.underflow_o, if_fwft.error_o);
        check_eq("std.rvalid",  32'(if_std.rvalid_o),  32'(m_rv));
        check_eq("std.rdata",   32'(if_std.rdata_o),   32'(m_rd));
        check_eq("fwft.rvalid", 32'(if_fwft.rvalid_o), 32'(mq.size() != 0));
        check_eq("fwft.rdata",  32'(if_fwft.rdata_o),  32'(head));
    endtask

    task automatic drive(input bit wr, input logic [W-1:0] wd, input bit rd, input bit clr);
        if_std.wr_en_i   = wr;  if_fwft.wr_en_i   = wr;
        if_std.wdata_i   = wd;  if_fwft.wdata_i   = wd;
        if_std.rd_en_i   = rd;  if_fwft.rd_en_i   = rd;
        if_std.clr_err_i = clr; if_fwft.clr_err_i = clr;
    endtask

    // One clock of stimulus; model advances by the FIFO rules, outputs checked 1 unit after the edge.
    task automatic cycle(input bit wr, input logic [W-1:0] wd, input bit rd, input bit clr);
        bit is_full, is_empty;
        drive(wr, wd, rd, clr);
        is_full  = (mq.size() == D);
        is_empty = (mq.size() == 0);
        if (wr && is_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (rd && is_empty) m_unf = 1'b1;
        else if (clr)       m_unf = 1'b0;
        m_rv = 1'b0;
        if (rd && !is_empty) begin
            m_rd = mq.pop_front();
            m_rv = 1'b1;
        end
        if (wr && !is_full) mq.push_back(wd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_i = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = '0;
        #1;
        check_all();
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain_all();
        while (mq.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        apply_reset();

        // Fill with 0x00..0x0F then drain in order.
        for (int i = 0; i < 16; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        drain_all();

        // Overflow: rejected write of 0xAA, sticky until cleared.
        fill(16);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        drain_all();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Underflow, then simultaneous read/write at count 5; empty + both requests.
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        fill(4);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        drain_all();

        // FWFT head visible one cycle after write into empty FIFO, then popped.
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Pointer wrap: 40 concurrent write/read pairs around a standing level of 3.
        fill(3);
        for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        drain_all();

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 60; i++) begin
                cycle($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 25), W'($urandom),
                      $urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 75),
                      $urandom_range(0, 15) == 0);
            end
        end
        drain_all();
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset at count 7, then 0x33 round trip.
        fill(7);
        apply_reset();
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
